// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//
// Measures one full period and the high time of a divided clock, sampled in
// the source clock domain, and checks the period against an expected divide
// ratio with an absolute tolerance. One measurement runs per start request.
// The result is reported with a single-cycle strobe.
//
// Parameters
//   CNT_W       width of the period, high-time and timeout counters
//   EXP_PERIOD  expected period in clk cycles
//   TOL         allowed absolute deviation of the period from EXP_PERIOD
//   TIMEOUT     cycle budget for one measurement (2 <= TIMEOUT < 2**CNT_W)
//
// Ports
//   clk         source clock (the one that also drives the divider)
//   rst         synchronous, active-high reset
//   clk_div_in  divided clock under test
//   start       one-cycle measurement request, ignored unless idle
//   busy        high while a measurement is in progress
//   meas_valid  one-cycle strobe; the result outputs change only here
//   period      measured rise-to-rise period (0 on timeout)
//   high_time   measured rise-to-fall time (0 on timeout)
//   period_ok   period within EXP_PERIOD +/- TOL
//   timeout     measurement aborted because an edge never arrived
module clk_div_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div_in,
  input  logic             start,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_ok,
  output logic             timeout
);

  typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, DONE} state_t;

  localparam logic [CNT_W-1:0]    T_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_PERIOD);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

  state_t               state;
  logic                 s1;
  logic                 s2;
  logic [CNT_W-1:0]     t;
  logic [CNT_W-1:0]     hi_cap;
  logic                 rise;
  logic                 fall;
  logic                 edge_seen;
  logic                 abort;
  logic signed [CNT_W:0] dev;
  logic                 in_tol;

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

  // The edge each waiting state is looking for; an arriving edge wins over
  // the timeout when both happen in the same cycle.
  always_comb begin
    edge_seen = 1'b0;
    case (state)
      ARM, LOW: edge_seen = rise;
      HIGH:     edge_seen = fall;
      default:  edge_seen = 1'b0;
    endcase
  end

  assign abort = ((state == ARM) || (state == HIGH) || (state == LOW)) &&
                 (t == T_LAST) && !edge_seen;

  // One extra bit with sign so that t < EXP_PERIOD yields a negative
  // deviation instead of wrapping.
  assign dev    = $signed({1'b0, t}) - EXP_S;
  assign in_tol = (dev <= TOL_S) && (dev >= -TOL_S);

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      t          <= '0;
      hi_cap     <= '0;
      // Reset high so an input already high at release is not a rise.
      s1         <= 1'b1;
      s2         <= 1'b1;
      meas_valid <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      period_ok  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s1         <= clk_div_in;
      s2         <= s1;
      meas_valid <= 1'b0;

      if (abort) begin
        state      <= DONE;
        meas_valid <= 1'b1;
        period     <= '0;
        high_time  <= '0;
        period_ok  <= 1'b0;
        timeout    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= ARM;
              t     <= '0;
            end
          end
          ARM: begin
            if (rise) begin
              state <= HIGH;
              t     <= CNT_W'(1);
            end else begin
              t <= t + 1'b1;
            end
          end
          HIGH: begin
            t <= t + 1'b1;
            if (fall) begin
              state  <= LOW;
              hi_cap <= t;
            end
          end
          LOW: begin
            t <= t + 1'b1;
            if (rise) begin
              // Results are loaded on entry to DONE so they are visible
              // in the same cycle as the strobe.
              state      <= DONE;
              meas_valid <= 1'b1;
              period     <= t;
              high_time  <= hi_cap;
              period_ok  <= in_tol;
              timeout    <= 1'b0;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
